// File: rtl/out_pass4_frame_config_pkg.sv
// Shared mode encodings and widths for the four-channel output pass-through block.
package out_pass4_frame_config_pkg;

    localparam logic [1:0] MODE_COMB    = 2'b00;
    localparam logic [1:0] MODE_REG     = 2'b01;
    localparam logic [1:0] MODE_REG2    = 2'b10;
    localparam logic [1:0] MODE_STRETCH = 2'b11;

    localparam int unsigned StretchLenW = 3;
    localparam int unsigned CntW        = 4;

endpackage

// File: rtl/out_pass_chan.sv
// One output channel: two stage registers, optional edge-triggered pulse stretcher, output mux.
// Stretching is compiled in only when OUTPASS_PULSE_STRETCH_EN is defined.
module out_pass_chan
    import out_pass4_frame_config_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             mode_i,
    input  logic [StretchLenW-1:0] len_i,
    input  logic                   in_i,
    output logic                   out_o
);

    logic stage1_q;
    logic stage2_q;
    logic stretch_out;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage1_q <= 1'b0;
            stage2_q <= 1'b0;
        end else begin
            stage1_q <= in_i;
            stage2_q <= stage1_q;
        end
    end

`ifdef OUTPASS_PULSE_STRETCH_EN
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            rise;

    // stage1_q holds In from the preceding edge, so it doubles as the edge history.
    assign rise = in_i & ~stage1_q;

    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = CntW'(len_i) + CntW'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stretch_out = (cnt_q != '0);
`else
    logic unused_len;
    assign unused_len  = ^len_i;
    assign stretch_out = stage1_q;
`endif

    always_comb begin
        out_o = in_i;
        case (mode_i)
            MODE_COMB:    out_o = in_i;
            MODE_REG:     out_o = stage1_q;
            MODE_REG2:    out_o = stage2_q;
            MODE_STRETCH: out_o = stretch_out;
            default:      out_o = in_i;
        endcase
    end

endmodule

// File: rtl/out_pass4_frame_config.sv
// Four independent output channels with per-channel mode select and a shared stretch length.
// Mode-11 pulse stretching exists only when OUTPASS_PULSE_STRETCH_EN is defined.
module out_pass4_frame_config
    import out_pass4_frame_config_pkg::*;
#(
    parameter int unsigned NoConfigBits = 11
) (
    input  logic                    UserCLK,
    input  logic                    UserRST,
    input  logic                    I0,
    input  logic                    I1,
    input  logic                    I2,
    input  logic                    I3,
    output logic                    O0,
    output logic                    O1,
    output logic                    O2,
    output logic                    O3,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    logic [3:0]             in_vec;
    logic [3:0]             out_vec;
    logic [StretchLenW-1:0] len;

    assign in_vec = {I3, I2, I1, I0};
    assign len    = ConfigBits[10:8];

    for (genvar i = 0; i < 4; i++) begin : g_chan
        out_pass_chan u_chan (
            .clk_i  (UserCLK),
            .rst_i  (UserRST),
            .mode_i (ConfigBits[2*i +: 2]),
            .len_i  (len),
            .in_i   (in_vec[i]),
            .out_o  (out_vec[i])
        );
    end

    assign O0 = out_vec[0];
    assign O1 = out_vec[1];
    assign O2 = out_vec[2];
    assign O3 = out_vec[3];

endmodule
